// File: rtl/frogger_pkg.sv
// frogger_pkg: shared types and constants for the frame-driven Frogger blocks.
//   coord_t       - 11-bit screen coordinate
//   sched_state_t - lane object scheduler sequence states
//   SCREEN_W/H    - visible raster size
//   *_DEF         - default lane geometry (X wrap modulus, object box size)
//   wrap_step     - one X motion step with wrap into 0..xmod-1
package frogger_pkg;

  typedef logic [10:0] coord_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MOVE  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } sched_state_t;

  localparam int SCREEN_W  = 640;
  localparam int SCREEN_H  = 480;
  localparam int XMOD_DEF  = 704;
  localparam int OBJ_W_DEF = 64;
  localparam int OBJ_H_DEF = 32;

  // Moves x by speed in the given direction (1 = right) and wraps into
  // 0..xmod-1. x is assumed already inside that range, so one correction
  // is always enough.
  function automatic coord_t wrap_step(input coord_t      x,
                                       input logic [3:0]  speed,
                                       input logic        dir,
                                       input logic [11:0] xmod);
    logic [11:0] x12;
    logic [11:0] sp12;
    logic [11:0] res;
    x12  = {1'b0, x};
    sp12 = {8'd0, speed};
    if (dir) begin
      res = x12 + sp12;
      if (res >= xmod) res = res - xmod;
    end else begin
      res = (x12 < sp12) ? (x12 + xmod - sp12) : (x12 - sp12);
    end
    return res[10:0];
  endfunction

endpackage

// File: rtl/frame_edge_sync.sv
// frame_edge_sync: brings an asynchronous frame strobe (VGA vsync) into the
// clk domain through two flops and emits a one-cycle pulse on its rising edge.
// Ports:
//   clk      - destination clock
//   rst_n    - asynchronous active-low reset, clears all flops
//   async_in - frame strobe from the foreign clock domain
//   rise     - one-cycle pulse after a synchronized 0->1 transition
module frame_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  logic meta_q;
  logic sync_q;
  logic sync_d_q;

  // NOTE: sequential state uses non-blocking assignments so each flop in the
  // chain samples its neighbour's pre-edge value, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      sync_d_q <= 1'b0;
    end else begin
      meta_q   <= async_in;
      sync_q   <= meta_q;
      sync_d_q <= sync_q;
    end
  end

  assign rise = sync_q & ~sync_d_q;

endmodule

// File: rtl/lane_object_scheduler.sv
// lane_object_scheduler: per-frame motion and collision sequencer for the lane
// objects drawn by the colour mapper. Each frame_clk rising edge runs
// MOVE (one object per cycle through a shared wrap adder), then CHECK (one
// object per cycle against the frog box), then DONE (publish hit result).
// Ports:
//   Clk, Reset_n          - system clock, asynchronous active-low reset
//   frame_clk             - VGA vsync, asynchronous to Clk
//   cfg_valid/cfg_ready   - configuration write handshake (ready only in IDLE)
//   cfg_idx, cfg_x, cfg_y, cfg_speed, cfg_dir, cfg_en - per-object write data
//   frog_x/y/w/h          - frog box, must be stable during a frame
//   obj_x, obj_y          - packed positions, object i at bits [11i+10:11i]
//   busy                  - sequence in progress
//   frame_done            - one-cycle pulse in the DONE cycle
//   hit, hit_idx          - overlap result of the last completed frame
//   overrun               - only with LANE_SCHED_OVERRUN_EN: an edge arrived
//                           while busy; cleared by a write to cfg_idx all-ones
// Build option: define LANE_SCHED_OVERRUN_EN to add the overrun flag.
module lane_object_scheduler
  import frogger_pkg::*;
#(
  parameter int NUM_OBJ = 4,
  parameter int XMOD    = XMOD_DEF,
  parameter int OBJ_W   = OBJ_W_DEF,
  parameter int OBJ_H   = OBJ_H_DEF,
  localparam int IDX_W  = $clog2(NUM_OBJ)
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   frame_clk,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [IDX_W-1:0]       cfg_idx,
  input  coord_t                 cfg_x,
  input  coord_t                 cfg_y,
  input  logic [3:0]             cfg_speed,
  input  logic                   cfg_dir,
  input  logic                   cfg_en,
  input  coord_t                 frog_x,
  input  coord_t                 frog_y,
  input  coord_t                 frog_w,
  input  coord_t                 frog_h,
  output logic [NUM_OBJ*11-1:0]  obj_x,
  output logic [NUM_OBJ*11-1:0]  obj_y,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   hit,
  output logic [IDX_W-1:0]       hit_idx
`ifdef LANE_SCHED_OVERRUN_EN
  ,
  output logic                   overrun
`endif
);

  localparam logic [11:0] XMOD12  = 12'(XMOD);
  localparam coord_t      XMOD11  = coord_t'(XMOD);
  localparam logic [11:0] OBJ_W12 = 12'(OBJ_W);
  localparam logic [11:0] OBJ_H12 = 12'(OBJ_H);

  sched_state_t     state, state_next;
  logic [IDX_W-1:0] idx;
  logic             last_idx;
  logic             frame_edge;

  coord_t     x_q     [NUM_OBJ];
  coord_t     y_q     [NUM_OBJ];
  logic [3:0] speed_q [NUM_OBJ];
  logic       dir_q   [NUM_OBJ];
  logic       en_q    [NUM_OBJ];

  logic             found;
  logic [IDX_W-1:0] found_idx;

  logic   cfg_write, cfg_clear, cfg_load;
  coord_t cfg_x_wrapped;
  coord_t cur_x, cur_y, moved_x;
  logic   overlap;

  frame_edge_sync u_frame_sync (
    .clk      (Clk),
    .rst_n    (Reset_n),
    .async_in (frame_clk),
    .rise     (frame_edge)
  );

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_next;
  end

  assign last_idx = (idx == IDX_W'(NUM_OBJ - 1));

  // NOTE: every variable written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (frame_edge) state_next = MOVE;
      MOVE:    if (last_idx)   state_next = CHECK;
      CHECK:   if (last_idx)   state_next = DONE;
      DONE:                    state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  assign busy       = (state != IDLE);
  assign cfg_ready  = (state == IDLE);
  assign frame_done = (state == DONE);

  // Object pointer walks 0..NUM_OBJ-1 once in MOVE and once in CHECK.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      idx <= '0;
    end else if ((state == MOVE) || (state == CHECK)) begin
      idx <= last_idx ? '0 : idx + 1'b1;
    end else begin
      idx <= '0;
    end
  end

  // ---------------------------------------------------------- cfg port
  assign cfg_write = cfg_valid && cfg_ready;
`ifdef LANE_SCHED_OVERRUN_EN
  assign cfg_clear = cfg_write && (cfg_idx == '1);
`else
  assign cfg_clear = 1'b0;
`endif
  // Indices past the last object are accepted but dropped.
  assign cfg_load      = cfg_write && !cfg_clear && (32'(cfg_idx) < 32'(NUM_OBJ));
  assign cfg_x_wrapped = (cfg_x >= XMOD11) ? (cfg_x - XMOD11) : cfg_x;

  // ------------------------------------------------- shared datapath
  assign cur_x   = x_q[idx];
  assign cur_y   = y_q[idx];
  assign moved_x = en_q[idx] ? wrap_step(cur_x, speed_q[idx], dir_q[idx], XMOD12) : cur_x;

  // Box edges are inclusive on both sides; 12-bit sums keep the carry.
  assign overlap = ({1'b0, frog_x} <= ({1'b0, cur_x} + OBJ_W12))              &&
                   ({1'b0, cur_x}  <= ({1'b0, frog_x} + {1'b0, frog_w}))      &&
                   ({1'b0, frog_y} <= ({1'b0, cur_y} + OBJ_H12))              &&
                   ({1'b0, cur_y}  <= ({1'b0, frog_y} + {1'b0, frog_h}));

  // NOTE: the per-object file is small and must read as zero after reset, so
  // it lives in flops with an explicit reset rather than an inferred RAM.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        x_q[i]     <= '0;
        y_q[i]     <= '0;
        speed_q[i] <= '0;
        dir_q[i]   <= 1'b0;
        en_q[i]    <= 1'b0;
      end
    end else begin
      // Writes happen only in IDLE and motion only in MOVE, so they never collide.
      if (cfg_load) begin
        x_q[cfg_idx]     <= cfg_x_wrapped;
        y_q[cfg_idx]     <= cfg_y;
        speed_q[cfg_idx] <= cfg_speed;
        dir_q[cfg_idx]   <= cfg_dir;
        en_q[cfg_idx]    <= cfg_en;
      end
      if (state == MOVE) x_q[idx] <= moved_x;
    end
  end

  // ------------------------------------------------------ hit result
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      found     <= 1'b0;
      found_idx <= '0;
      hit       <= 1'b0;
      hit_idx   <= '0;
    end else begin
      case (state)
        CHECK: if (!found && overlap) begin
          found     <= 1'b1;
          found_idx <= idx;
        end
        DONE: begin
          hit       <= found;
          hit_idx   <= found ? found_idx : '0;
          found     <= 1'b0;
          found_idx <= '0;
        end
        default: ;
      endcase
    end
  end

`ifdef LANE_SCHED_OVERRUN_EN
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)                   overrun <= 1'b0;
    else if (frame_edge && busy)    overrun <= 1'b1;
    else if (cfg_clear)             overrun <= 1'b0;
  end
`endif

  // ------------------------------------------------------ packed views
  always_comb begin
    obj_x = '0;
    obj_y = '0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      obj_x[11*i +: 11] = x_q[i];
      obj_y[11*i +: 11] = y_q[i];
    end
  end

endmodule

// File: tb/tb_lane_object_scheduler.sv
// tb_lane_object_scheduler: directed bench for lane_object_scheduler with a
// frame-level reference model checked on every negative clock edge, plus
// hand-computed literal expectations for the key scenarios.
module tb_lane_object_scheduler;

  localparam int N         = 4;
  localparam int XM        = 704;
  localparam int OW        = 64;
  localparam int OH        = 32;
  localparam int IW        = $clog2(N);
  localparam int FRAME_LAT = 2 * N + 3;  // frame_clk rise to visible frame_done, in clocks

  logic              Clk = 1'b0;
  logic              Reset_n = 1'b0;
  logic              frame_clk = 1'b0;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [IW-1:0]     cfg_idx = '0;
  logic [10:0]       cfg_x = '0, cfg_y = '0;
  logic [3:0]        cfg_speed = '0;
  logic              cfg_dir = 1'b0, cfg_en = 1'b0;
  logic [10:0]       frog_x = '0, frog_y = 11'd400, frog_w = 11'd32, frog_h = 11'd32;
  logic [N*11-1:0]   obj_x, obj_y;
  logic              busy, frame_done, hit;
  logic [IW-1:0]     hit_idx;
`ifdef LANE_SCHED_OVERRUN_EN
  logic              overrun;
`endif

  lane_object_scheduler #(.NUM_OBJ(N), .XMOD(XM), .OBJ_W(OW), .OBJ_H(OH)) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .frame_clk  (frame_clk),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_idx    (cfg_idx),
    .cfg_x      (cfg_x),
    .cfg_y      (cfg_y),
    .cfg_speed  (cfg_speed),
    .cfg_dir    (cfg_dir),
    .cfg_en     (cfg_en),
    .frog_x     (frog_x),
    .frog_y     (frog_y),
    .frog_w     (frog_w),
    .frog_h     (frog_h),
    .obj_x      (obj_x),
    .obj_y      (obj_y),
    .busy       (busy),
    .frame_done (frame_done),
    .hit        (hit),
    .hit_idx    (hit_idx)
`ifdef LANE_SCHED_OVERRUN_EN
    ,
    .overrun    (overrun)
`endif
  );

  initial forever #5 Clk = ~Clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int get_x(input int i);
    return int'(obj_x[11*i +: 11]);
  endfunction

  function automatic int get_y(input int i);
    return int'(obj_y[11*i +: 11]);
  endfunction

  // ------------------------------------------------------------ model
  // phase = clocks since the accepted edge-pulse cycle (-1 when idle).
  int mx[N], my[N], msp[N];
  bit mdir[N], men[N];
  int phase, cd, mhit_idx;
  bit mhit, movr, prev_fclk;
  bit snap_valid, snap_ready, snap_dir, snap_en;
  int snap_idx, snap_x, snap_y, snap_sp;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mx[i] = 0; my[i] = 0; msp[i] = 0; mdir[i] = 0; men[i] = 0;
    end
    phase = -1; cd = 0; mhit = 0; mhit_idx = 0; movr = 0;
    prev_fclk = 0; snap_valid = 0; snap_ready = 0;
  endtask

  task automatic model_write();
`ifdef LANE_SCHED_OVERRUN_EN
    if (snap_idx == (1 << IW) - 1) begin
      movr = 0;
      return;
    end
`endif
    if (snap_idx < N) begin
      mx[snap_idx]   = (snap_x >= XM) ? snap_x - XM : snap_x;
      my[snap_idx]   = snap_y;
      msp[snap_idx]  = snap_sp;
      mdir[snap_idx] = snap_dir;
      men[snap_idx]  = snap_en;
    end
  endtask

  task automatic model_hit();
    int fx, fy, fw, fh;
    fx = int'(frog_x); fy = int'(frog_y); fw = int'(frog_w); fh = int'(frog_h);
    mhit = 0; mhit_idx = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (fx <= mx[i] + OW && mx[i] <= fx + fw && fy <= my[i] + OH && my[i] <= fy + fh) begin
        mhit = 1; mhit_idx = i;
      end
    end
  endtask

  always @(negedge Clk) begin
    if (!Reset_n) begin
      model_reset();
    end else begin
      if (snap_valid && snap_ready) model_write();
      if (phase >= 0) begin
        phase++;
        if (phase >= 2 && phase < 2 + N && men[phase-2]) begin
          if (mdir[phase-2]) mx[phase-2] = (mx[phase-2] + msp[phase-2]) % XM;
          else               mx[phase-2] = (mx[phase-2] - msp[phase-2] + XM) % XM;
        end
        if (phase == 2 * N + 2) begin
          model_hit();
          phase = -1;
        end
      end
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          if (phase < 1) phase = 0;
          else           movr = 1;
        end
      end
    end
    check("busy", int'(busy), int'(phase >= 1));
    check("cfg_ready", int'(cfg_ready), int'(phase < 1));
    check("frame_done", int'(frame_done), int'(phase == 2 * N + 1));
    check("hit", int'(hit), int'(mhit));
    check("hit_idx", int'(hit_idx), mhit_idx);
    for (int i = 0; i < N; i++) begin
      check($sformatf("obj_x[%0d]", i), get_x(i), mx[i]);
      check($sformatf("obj_y[%0d]", i), get_y(i), my[i]);
    end
`ifdef LANE_SCHED_OVERRUN_EN
    check("overrun", int'(overrun), int'(movr));
`endif
    if (Reset_n) begin
      snap_valid = cfg_valid;
      snap_ready = (phase < 1);
      snap_idx   = int'(cfg_idx);
      snap_x     = int'(cfg_x);
      snap_y     = int'(cfg_y);
      snap_sp    = int'(cfg_speed);
      snap_dir   = cfg_dir;
      snap_en    = cfg_en;
      if (frame_clk && !prev_fclk) cd = 2;
      prev_fclk = frame_clk;
    end
  end

  // --------------------------------------------------------- stimulus
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_cfg(input int idx, input int x, input int y, input int sp,
                         input bit dir, input bit en);
    cfg_idx = IW'(idx); cfg_x = 11'(x); cfg_y = 11'(y);
    cfg_speed = 4'(sp); cfg_dir = dir; cfg_en = en;
  endtask

  task automatic cfg_wr(input int idx, input int x, input int y, input int sp,
                        input bit dir, input bit en);
    set_cfg(idx, x, y, sp, dir, en);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    tick();
  endtask

  // Waits for frame_done with a bound; returns clocks waited or -1.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (frame_done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_frame(input string tag);
    int lat;
    frame_clk = 1'b1;
    wait_done(lat);
    check({tag, " frame_done latency"}, lat, FRAME_LAT);
    frame_clk = 1'b0;
    tick();
    check({tag, " busy after frame"}, int'(busy), 0);
    repeat (3) tick();
  endtask

  initial begin
    int lat, pulses;
    repeat (3) tick();
    check("reset busy", int'(busy), 0);
    check("reset hit", int'(hit), 0);
    check("reset obj_x", int'(obj_x), 0);
    Reset_n = 1'b1;
    repeat (2) tick();

    // All motion disabled: positions stay at zero.
    run_frame("idle frame");
    check("idle frame obj_x", int'(obj_x), 0);
    check("idle frame hit", int'(hit), 0);

    // Right wrap 700+6 -> 2, then 8.
    cfg_wr(0, 700, 0, 6, 1'b1, 1'b1);
    run_frame("right1");
    check("right wrap x0", get_x(0), 2);
    run_frame("right2");
    check("right second x0", get_x(0), 8);

    // Left wrap 3-5 -> 702.
    cfg_wr(1, 3, 0, 5, 1'b0, 1'b1);
    run_frame("left");
    check("left wrap x1", get_x(1), 702);
    check("left frame x0", get_x(0), 14);

    // Write with x beyond the wrap modulus is reduced once.
    cfg_wr(3, 720, 5, 0, 1'b0, 1'b0);
    check("cfg x reduce", get_x(3), 16);

    // Collision priority: both obj2 and obj3 overlap, lowest index wins.
    frog_x = 11'd100; frog_y = 11'd200; frog_w = 11'd32; frog_h = 11'd32;
    cfg_wr(2, 120, 210, 0, 1'b0, 1'b0);
    cfg_wr(3, 90, 220, 0, 1'b0, 1'b0);
    run_frame("collide");
    check("collide hit", int'(hit), 1);
    check("collide hit_idx", int'(hit_idx), 2);
    frog_y = 11'd400;
    run_frame("miss");
    check("miss hit", int'(hit), 0);
    check("miss hit_idx", int'(hit_idx), 0);

    // Write landing in the edge-pulse cycle is used by that frame.
    cfg_wr(0, 100, 0, 6, 1'b1, 1'b1);
    frame_clk = 1'b1;
    tick();
    tick();
    set_cfg(0, 100, 0, 3, 1'b1, 1'b1);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    check("edge-cycle write busy", int'(busy), 1);
    wait_done(lat);
    check("edge-cycle latency", lat, FRAME_LAT - 3);
    frame_clk = 1'b0;
    repeat (3) tick();
    check("edge-cycle write x0", get_x(0), 103);

    // Second edge arriving during MOVE is dropped: only one move happens.
    frame_clk = 1'b1;
    tick();
    tick();
    frame_clk = 1'b0;
    tick();
    frame_clk = 1'b1;
    wait_done(lat);
    check("double edge latency", lat, FRAME_LAT - 3);
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (frame_done) pulses++;
    end
    check("skipped frame pulses", pulses, 0);
    check("skipped frame x0", get_x(0), 106);
`ifdef LANE_SCHED_OVERRUN_EN
    check("overrun set", int'(overrun), 1);
    cfg_wr((1 << IW) - 1, 0, 0, 0, 1'b0, 1'b0);
    check("overrun cleared", int'(overrun), 0);
    check("clear write discarded x3", get_x(3), 90);
`endif
    frame_clk = 1'b0;
    repeat (3) tick();

    // Set hit, then reset in the middle of CHECK.
    frog_y = 11'd200;
    run_frame("prehit");
    check("prehit hit", int'(hit), 1);
    frame_clk = 1'b1;
    repeat (8) tick();
    check("mid-check busy", int'(busy), 1);
    Reset_n = 1'b0;
    frame_clk = 1'b0;
    #1;
    check("async reset busy", int'(busy), 0);
    check("async reset hit", int'(hit), 0);
    check("async reset obj_x", int'(obj_x), 0);
    check("async reset obj_y", int'(obj_y), 0);
    check("async reset frame_done", int'(frame_done), 0);
    tick();
    tick();
    Reset_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (frame_done) pulses++;
    end
    check("abandoned frame pulses", pulses, 0);
    cfg_wr(0, 10, 0, 2, 1'b1, 1'b1);
    run_frame("post-reset");
    check("post-reset x0", get_x(0), 12);
    check("post-reset hit", int'(hit), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
